// File: rtl/instr_encoder.sv
// instr_encoder: encodes LEGv8 instruction descriptions into 32-bit words and
// buffers them in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, in_op=7 is accepted,
// dropped, and latches the sticky err flag; otherwise it encodes as all ones.
module instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rn,
    input  logic [4:0]  in_rm,
    input  logic [18:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [15:0] count,
    output logic        err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OPC_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OPC_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OPC_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
    localparam logic [7:0]  OPC_CBZ  = 8'b1011_0100;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [15:0]   count_q;
    logic          err_q;

    logic [31:0]   enc_word_c;
    logic          illegal_c;
    logic          full_c;
    logic          empty_c;
    logic          accept_c;
    logic          push_c;
    logic          pop_c;

    // Translate the request fields into the LEGv8 word for the selected format
    always_comb begin
        enc_word_c = 32'hFFFF_FFFF;
        case (in_op)
            3'd0:    enc_word_c = {OPC_ADD, in_rm, 6'd0, in_rn, in_rd};
            3'd1:    enc_word_c = {OPC_SUB, in_rm, 6'd0, in_rn, in_rd};
            3'd2:    enc_word_c = {OPC_AND, in_rm, 6'd0, in_rn, in_rd};
            3'd3:    enc_word_c = {OPC_ORR, in_rm, 6'd0, in_rn, in_rd};
            3'd4:    enc_word_c = {OPC_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
            3'd5:    enc_word_c = {OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
            3'd6:    enc_word_c = {OPC_CBZ, in_imm, in_rd};
            default: enc_word_c = 32'hFFFF_FFFF;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_c = (in_op == 3'd7);
`else
    assign illegal_c = 1'b0;
`endif

    assign full_c    = (occ == OW'(DEPTH));
    assign empty_c   = (occ == '0);
    assign accept_c  = in_valid && !full_c;
    assign push_c    = accept_c && !illegal_c;
    assign pop_c     = out_ready && !empty_c;

    assign in_ready  = !full_c;
    assign out_valid = !empty_c;
    assign out_instr = empty_c ? 32'd0 : mem[rd_ptr];
    assign count     = count_q;
    assign err       = err_q;

    // Storage array; contents are don't-care until occupancy says otherwise
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= enc_word_c;
        end
    end

    // Pointers, occupancy, pop counter and sticky trap flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr  <= rd_ptr + AW'(1);
                count_q <= count_q + 16'd1;
            end
            case ({push_c, pop_c})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
            if (accept_c && illegal_c) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rn = '0;
    logic [4:0]  in_rm = '0;
    logic [18:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [15:0] count;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] q[$];
    int          exp_count = 0;
    logic        exp_err = 1'b0;
    bit          trap_mode;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    // Reference encoding built by arithmetic field placement
    function automatic logic [31:0] ref_enc(int op, int rd, int rn, int rm, int imm);
        longint v;
        case (op)
            0: v = longint'('h458) * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            1: v = longint'('h658) * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            2: v = longint'('h450) * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            3: v = longint'('h550) * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
            4: v = longint'('h7C2) * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
            5: v = longint'('h7C0) * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
            6: v = longint'('hB4) * (64'd1 << 24) + (imm % 524288) * 32 + rd;
            default: v = 64'hFFFF_FFFF;
        endcase
        return 32'(v);
    endfunction

    task automatic set_req(input bit v, input int op, input int rd, input int rn, input int rm, input int imm);
        in_valid = v;
        in_op    = 3'(op);
        in_rd    = 5'(rd);
        in_rn    = 5'(rn);
        in_rm    = 5'(rm);
        in_imm   = 19'(imm);
    endtask

    task automatic rand_req(input bit v);
        set_req(v, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 524287)));
    endtask

    // Advance one clock; the model decides handshakes from its own occupancy
    task automatic tick();
        bit acc;
        bit pp;
        logic [31:0] w;
        acc = in_valid && (q.size() < DEPTH) && !reset;
        pp  = out_ready && (q.size() > 0) && !reset;
        w   = ref_enc(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), int'(in_imm));
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            exp_count = 0;
            exp_err = 1'b0;
        end else begin
            if (pp) begin
                void'(q.pop_front());
                exp_count = (exp_count + 1) % 65536;
            end
            if (acc) begin
                if (trap_mode && in_op == 3'd7) exp_err = 1'b1;
                else q.push_back(w);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(1'b0, 0, 0, 0, 0, 0);
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_instr !== 32'd0) begin n_bad++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        set_req(1'b1, 0, 1, 2, 3, 0);
        tick();
        set_req(1'b0, 0, 0, 0, 0, 0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_cmp++; if (out_instr !== 32'h8B03_0041) begin n_bad++; $display("FAIL add_word got %h want 8b030041", out_instr); end
        tick();
        n_cmp++; if (count !== 16'd1) begin n_bad++; $display("FAIL add_count got %0d want 1", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_drained got %b want 0", out_valid); end
        set_req(1'b1, 4, 5, 6, 0, 8);
        tick();
        set_req(1'b0, 0, 0, 0, 0, 0);
        n_cmp++; if (out_instr !== 32'hF840_80C5) begin n_bad++; $display("FAIL ldur_word got %h want f84080c5", out_instr); end
        tick();
        set_req(1'b1, 6, 7, 0, 0, 4);
        tick();
        set_req(1'b0, 0, 0, 0, 0, 0);
        n_cmp++; if (out_instr !== 32'hB400_0087) begin n_bad++; $display("FAIL cbz_word got %h want b4000087", out_instr); end
        tick();
        n_cmp++; if (count !== 16'(exp_count)) begin n_bad++; $display("FAIL dir_count got %0d want %0d", count, exp_count); end
    endtask

    task automatic test_backpressure();
        logic [31:0] head;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_req(1'b1);
            in_op = 3'(i % 7);
            tick();
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full got %b want 0", in_ready); end
        head = q[0];
        set_req(1'b1, 1, 9, 10, 11, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_instr !== head || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold got %h/%b want %h/1", out_instr, out_valid, head);
            end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_held got %b want 0", in_ready); end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b want 1", in_ready); end
        tick();
        set_req(1'b0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            n_cmp++; if (out_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL bp_drain_valid got %b want %b", out_valid, q.size() > 0); end
            if (q.size() > 0) begin
                n_cmp++; if (out_instr !== q[0]) begin n_bad++; $display("FAIL bp_order got %h want %h", out_instr, q[0]); end
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        set_req(1'b1, 7, 3, 4, 5, 6);
        tick();
        set_req(1'b0, 0, 0, 0, 0, 0);
        if (trap_mode) begin
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL trap_err got %b want 1", err); end
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL trap_valid got %b want 0", out_valid); end
        end else begin
            n_cmp++; if (out_instr !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL undef_word got %h want ffffffff", out_instr); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL undef_err got %b want 0", err); end
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL illegal_sticky got %b want %b", err, exp_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_req(1'b1);
            in_op = 3'(i % 7);
            tick();
        end
        set_req(1'b0, 0, 0, 0, 0, 0);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_req(1'b1);
            in_op = 3'(i % 7);
            tick();
        end
        set_req(1'b0, 0, 0, 0, 0, 0);
        n_cmp++; if (count !== 16'd5) begin n_bad++; $display("FAIL mid_pre_count got %0d want 5", count); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 16'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL mid_async got v=%b c=%0d e=%b want 0/0/0", out_valid, count, err);
        end
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ghost got %b want 0", out_valid); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_req(1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
            n_cmp++; if (in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() > 0)) begin
                n_bad++; $display("FAIL rnd_flags got r=%b v=%b want occ=%0d", in_ready, out_valid, q.size());
            end
            if (q.size() > 0) begin
                n_cmp++; if (out_instr !== q[0]) begin n_bad++; $display("FAIL rnd_word got %h want %h", out_instr, q[0]); end
            end
            n_cmp++; if (count !== 16'(exp_count) || err !== exp_err) begin
                n_bad++; $display("FAIL rnd_cnt_err got %0d/%b want %0d/%b", count, err, exp_count, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_req(1'b1);
            in_op = 3'($urandom_range(0, 6));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            rand_req(1'b1);
            in_op = 3'($urandom_range(0, 6));
            tick();
            n_cmp++; if (out_instr !== q[0] || q.size() != 2) begin
                n_bad++; $display("FAIL b2b_word got %h want %h occ %0d", out_instr, q[0], q.size());
            end
            n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL b2b_flags got r=%b v=%b want 1/1", in_ready, out_valid);
            end
        end
        set_req(1'b0, 0, 0, 0, 0, 0);
        n_cmp++; if (count !== 16'd65534) begin n_bad++; $display("FAIL b2b_count got %0d want 65534", count); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== q[0]) begin n_bad++; $display("FAIL b2b_last got %h want %h", out_instr, q[0]); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b want 0", out_valid); end
        n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL count_wrap got %0d want 0", count); end
    endtask

    initial begin
`ifdef ILLEGAL_TRAP_EN
        trap_mode = 1'b1;
`else
        trap_mode = 1'b0;
`endif
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
